// File: rtl/wb_ram_bist_pkg.sv
// Shared types and helpers for the Wishbone RAM BIST master: FSM states,
// byte-select constant and the data pattern generator.
package wb_ram_bist_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WR_REQ,
        WR_GAP,
        RD_REQ,
        RD_GAP,
        DONE
    } state_t;

    localparam logic [3:0] SEL_ALL = 4'hF;

    // Upper half carries the inverted index so every address line toggles data in both halves.
    function automatic logic [31:0] bist_pattern(input logic [31:0] seed,
                                                 input logic [15:0] i16,
                                                 input logic        inv);
        return seed ^ {~i16, i16} ^ {32{inv}};
    endfunction

endpackage

// File: rtl/wb_ram_bist_pattern.sv
// Expected-data generator for one word: index and pass number in, 32-bit pattern out.
// Feeds both the write-data path and the read compare.
module wb_ram_bist_pattern
    import wb_ram_bist_pkg::*;
#(
    parameter int          ADDR_WIDTH   = 8,
    parameter logic [31:0] PATTERN_SEED = 32'hA5C3_0F96
) (
    input  logic [ADDR_WIDTH-1:0] idx,
    input  logic                  pass,
    output logic [31:0]           data
);

    logic [15:0] i16;

    always_comb begin
        i16                 = '0;
        i16[ADDR_WIDTH-1:0] = idx;
    end

    assign data = bist_pattern(PATTERN_SEED, i16, pass);

endmodule

// File: rtl/wb_ram_bist_master.sv
// Wishbone classic initiator that writes/reads back a pattern over the whole RAM
// and reports pass/fail. Optional ack timeout abort enabled by WB_BIST_TIMEOUT_EN.
module wb_ram_bist_master
    import wb_ram_bist_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR      = 32'h3000_0000,
    parameter int          ADDR_WIDTH     = 8,
    parameter logic [31:0] PATTERN_SEED   = 32'hA5C3_0F96,
    parameter int          INVERT_PASS    = 1,
    parameter int          TIMEOUT_CYCLES = 64
) (
    input  logic                  wb_clk_i,
    input  logic                  wb_rst_ni,
    input  logic                  start_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  pass_o,
    output logic                  timeout_o,
    output logic [15:0]           err_cnt_o,
    output logic [ADDR_WIDTH-1:0] first_err_adr_o,
    output logic [31:0]           first_err_dat_o,
    output logic                  wbm_cyc_o,
    output logic                  wbm_stb_o,
    output logic                  wbm_we_o,
    output logic [3:0]            wbm_sel_o,
    output logic [31:0]           wbm_adr_o,
    output logic [31:0]           wbm_dat_o,
    input  logic [31:0]           wbm_dat_i,
    input  logic                  wbm_ack_i
);

    localparam logic [ADDR_WIDTH-1:0] LAST_IDX = '1;
    localparam logic [ADDR_WIDTH-1:0] IDX_ONE  = 1;
    localparam logic [15:0]           ERR_MAX  = 16'hFFFF;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] idx_q;
    logic                  pass_q;
    logic [15:0]           err_cnt_q;
    logic [ADDR_WIDTH-1:0] first_adr_q;
    logic [31:0]           first_dat_q;
    logic [31:0]           exp_dat;

    logic clr_run, pass_set, cmp_en, tmo_abort, tmo_expired;
    logic in_req, in_gap, idx_last, mismatch;

    assign in_req   = (state_q == WR_REQ) || (state_q == RD_REQ);
    assign in_gap   = (state_q == WR_GAP) || (state_q == RD_GAP);
    assign idx_last = (idx_q == LAST_IDX);
    assign mismatch = (wbm_dat_i != exp_dat);

    wb_ram_bist_pattern #(
        .ADDR_WIDTH  (ADDR_WIDTH),
        .PATTERN_SEED(PATTERN_SEED)
    ) u_pattern (
        .idx (idx_q),
        .pass(pass_q),
        .data(exp_dat)
    );

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) state_q <= IDLE;
        else            state_q <= state_d;
    end

    always_comb begin
        state_d   = state_q;
        clr_run   = 1'b0;
        pass_set  = 1'b0;
        cmp_en    = 1'b0;
        tmo_abort = 1'b0;
        unique case (state_q)
            IDLE, DONE: begin
                if (start_i) begin
                    state_d = WR_REQ;
                    clr_run = 1'b1;
                end
            end
            WR_REQ: begin
                if (wbm_ack_i) begin
                    state_d = WR_GAP;
                end else if (tmo_expired) begin
                    state_d   = DONE;
                    tmo_abort = 1'b1;
                end
            end
            // The slave re-acks a held strobe, so every access is followed by one idle cycle.
            WR_GAP: state_d = idx_last ? RD_REQ : WR_REQ;
            RD_REQ: begin
                if (wbm_ack_i) begin
                    state_d = RD_GAP;
                    cmp_en  = 1'b1;
                end else if (tmo_expired) begin
                    state_d   = DONE;
                    tmo_abort = 1'b1;
                end
            end
            RD_GAP: begin
                if (!idx_last) begin
                    state_d = RD_REQ;
                end else if ((INVERT_PASS != 0) && !pass_q) begin
                    state_d  = WR_REQ;
                    pass_set = 1'b1;
                end else begin
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            idx_q       <= '0;
            pass_q      <= 1'b0;
            err_cnt_q   <= '0;
            first_adr_q <= '0;
            first_dat_q <= '0;
        end else if (clr_run) begin
            idx_q       <= '0;
            pass_q      <= 1'b0;
            err_cnt_q   <= '0;
            first_adr_q <= '0;
            first_dat_q <= '0;
        end else begin
            if (in_gap)   idx_q  <= idx_last ? '0 : idx_q + IDX_ONE;
            if (pass_set) pass_q <= 1'b1;
            if (cmp_en && mismatch) begin
                if (err_cnt_q != ERR_MAX) err_cnt_q <= err_cnt_q + 16'd1;
                if (err_cnt_q == '0) begin
                    first_adr_q <= idx_q;
                    first_dat_q <= wbm_dat_i;
                end
            end
        end
    end

`ifdef WB_BIST_TIMEOUT_EN
    localparam int               TMO_W    = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [TMO_W-1:0] TMO_ONE  = 1;

    logic [TMO_W-1:0] tmo_cnt_q;
    logic             timeout_q;

    // Counts strobe cycles of the current access; the gap state clears it.
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            tmo_cnt_q <= '0;
            timeout_q <= 1'b0;
        end else begin
            tmo_cnt_q <= in_req ? tmo_cnt_q + TMO_ONE : '0;
            if (clr_run)        timeout_q <= 1'b0;
            else if (tmo_abort) timeout_q <= 1'b1;
        end
    end

    assign tmo_expired = in_req && (tmo_cnt_q == TMO_LAST);
    assign timeout_o   = timeout_q;
`else
    localparam int unused_timeout_cycles = TIMEOUT_CYCLES;
    assign tmo_expired = 1'b0;
    assign timeout_o   = 1'b0;
`endif

    assign busy_o          = (state_q != IDLE) && (state_q != DONE);
    assign done_o          = (state_q == DONE);
    assign pass_o          = done_o && (err_cnt_q == '0) && !timeout_o;
    assign err_cnt_o       = err_cnt_q;
    assign first_err_adr_o = first_adr_q;
    assign first_err_dat_o = first_dat_q;

    assign wbm_cyc_o = in_req;
    assign wbm_stb_o = in_req;
    assign wbm_we_o  = (state_q == WR_REQ);
    assign wbm_sel_o = in_req ? SEL_ALL : 4'h0;
    assign wbm_adr_o = in_req ? (BASE_ADDR | 32'(idx_q)) : 32'h0;
    assign wbm_dat_o = wbm_we_o ? exp_dat : 32'h0;

endmodule

// File: tb/tb_wb_ram_bist_master.sv
// BIST master driving a behavioural registered-ack RAM slave with injectable stuck-at bits.
module tb_wb_ram_bist_master;

    localparam int          AW      = 8;
    localparam int          DEPTH   = 1 << AW;
    localparam logic [31:0] BASE    = 32'h3000_0000;
    localparam logic [31:0] SEED    = 32'hA5C3_0F96;
    localparam int          INV     = 1;
    localparam int          TMO     = 64;
    localparam int          NPASS   = 1 + INV;
    localparam int          RUN_CYC = 6 * DEPTH * NPASS;
    localparam int          LIMIT   = RUN_CYC + 500;

    logic clk = 1'b0, rst_n = 1'b0, start = 1'b0;
    logic busy, done, pass, timeout;
    logic [15:0] err_cnt;
    logic [AW-1:0] fadr;
    logic [31:0] fdat;
    logic cyc, stb, we, ack;
    logic [3:0] sel;
    logic [31:0] adr, dat_o, dat_i;

    logic [31:0] mem   [DEPTH];
    logic [31:0] and_m [DEPTH];
    logic [31:0] or_m  [DEPTH];
    logic sup_rd7 = 1'b0;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    wb_ram_bist_master #(
        .BASE_ADDR(BASE), .ADDR_WIDTH(AW), .PATTERN_SEED(SEED),
        .INVERT_PASS(INV), .TIMEOUT_CYCLES(TMO)
    ) dut (
        .wb_clk_i(clk), .wb_rst_ni(rst_n), .start_i(start),
        .busy_o(busy), .done_o(done), .pass_o(pass), .timeout_o(timeout),
        .err_cnt_o(err_cnt), .first_err_adr_o(fadr), .first_err_dat_o(fdat),
        .wbm_cyc_o(cyc), .wbm_stb_o(stb), .wbm_we_o(we), .wbm_sel_o(sel),
        .wbm_adr_o(adr), .wbm_dat_o(dat_o), .wbm_dat_i(dat_i), .wbm_ack_i(ack)
    );

    // RAM slave: ack one cycle after strobe, never twice in a row; reads pass through fault masks.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ack   <= 1'b0;
            dat_i <= 32'h0;
        end else begin
            ack <= 1'b0;
            if (cyc && stb && !ack && !(sup_rd7 && !we && adr[AW-1:0] == 8'd7)) begin
                ack <= 1'b1;
                if (we) mem[adr[AW-1:0]] <= dat_o;
                else    dat_i <= (mem[adr[AW-1:0]] & ~and_m[adr[AW-1:0]]) | or_m[adr[AW-1:0]];
            end
        end
    end

    function automatic logic [31:0] ref_pat(input int i, input int p);
        logic [31:0] lo, hi;
        lo = 32'(i) & 32'h0000_FFFF;
        hi = (~lo & 32'h0000_FFFF) << 16;
        return SEED ^ hi ^ lo ^ ((p != 0) ? 32'hFFFF_FFFF : 32'h0);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Bus checker: access n of a run must hit word n%DEPTH, writes in even phases.
    int   acc_n    = 0;
    logic prev_ack = 1'b0;
    always @(negedge clk) begin
        int idx, ph;
        if (start && !busy) acc_n = 0;
        if (!rst_n) begin
            prev_ack = 1'b0;
        end else begin
            if (stb) chk("stb_has_cyc", 32'(cyc), 32'd1);
            if (prev_ack) chk("idle_after_ack", 32'(stb), 32'd0);
            if (stb && ack) begin
                idx = acc_n % DEPTH;
                ph  = acc_n / DEPTH;
                chk("bus_adr", adr, BASE | 32'(idx));
                chk("bus_we", 32'(we), (ph % 2 == 0) ? 32'd1 : 32'd0);
                chk("bus_sel", 32'(sel), 32'hF);
                if (we) chk("bus_wdat", dat_o, ref_pat(idx, ph / 2));
                acc_n++;
            end
            prev_ack = ack;
        end
    end

    task automatic clear_faults();
        for (int i = 0; i < DEPTH; i++) begin
            and_m[i] = 32'h0;
            or_m[i]  = 32'h0;
        end
    endtask

    task automatic model_run(output int ecnt, output int efa, output logic [31:0] efd);
        logic [31:0] w, r;
        ecnt = 0; efa = 0; efd = 32'h0;
        for (int p = 0; p < NPASS; p++)
            for (int i = 0; i < DEPTH; i++) begin
                w = ref_pat(i, p);
                r = (w & ~and_m[i]) | or_m[i];
                if (r != w) begin
                    if (ecnt == 0) begin efa = i; efd = r; end
                    ecnt++;
                end
            end
    endtask

    task automatic pulse_start();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
    endtask

    task automatic wait_done(input bit glitch, output int n);
        n = 0;
        while (done !== 1'b1 && n < LIMIT) begin
            @(posedge clk); #1;
            n++;
            start = glitch && (n == 100);
        end
        start = 1'b0;
        chk("done_reached", 32'(done), 32'd1);
    endtask

    task automatic chk_results(input string tag);
        int ecnt, efa;
        logic [31:0] efd;
        model_run(ecnt, efa, efd);
        chk({tag, "_pass"}, 32'(pass), (ecnt == 0) ? 32'd1 : 32'd0);
        chk({tag, "_err_cnt"}, 32'(err_cnt), 32'(ecnt));
        chk({tag, "_first_adr"}, 32'(fadr), 32'(efa));
        chk({tag, "_first_dat"}, fdat, efd);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_timeout"}, 32'(timeout), 32'd0);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_done"}, 32'(done), 32'd0);
        chk({tag, "_pass"}, 32'(pass), 32'd0);
        chk({tag, "_timeout"}, 32'(timeout), 32'd0);
        chk({tag, "_err_cnt"}, 32'(err_cnt), 32'd0);
        chk({tag, "_first_adr"}, 32'(fadr), 32'd0);
        chk({tag, "_first_dat"}, fdat, 32'd0);
        chk({tag, "_cyc"}, 32'(cyc), 32'd0);
        chk({tag, "_stb"}, 32'(stb), 32'd0);
        chk({tag, "_we"}, 32'(we), 32'd0);
        chk({tag, "_sel"}, 32'(sel), 32'd0);
        chk({tag, "_adr"}, adr, 32'd0);
        chk({tag, "_wdat"}, dat_o, 32'd0);
    endtask

    initial begin
        int n, bad, w, b;
        clear_faults();
        #2;
        chk_all_zero("reset");
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // Clean RAM
        pulse_start();
        wait_done(1'b0, n);
        chk("clean_cycles", 32'(n), 32'(RUN_CYC));
        chk_results("clean");
        chk("word10", mem[16], ref_pat(16, NPASS - 1));
        bad = 0;
        for (int i = 0; i < DEPTH; i++) if (mem[i] !== ref_pat(i, NPASS - 1)) bad++;
        chk("mem_image", 32'(bad), 32'd0);

        // Word 5 bit 3 stuck at 0, with a stray start mid-run
        and_m[5] = 32'h0000_0008;
        pulse_start();
        wait_done(1'b1, n);
        chk("sa0_cycles", 32'(n), 32'(RUN_CYC));
        chk_results("sa0");

        // Random stuck-at faults; first new start must clear previous results
        for (int r = 0; r < 3; r++) begin
            clear_faults();
            repeat ($urandom_range(1, 3)) begin
                w = $urandom_range(0, DEPTH - 1);
                b = $urandom_range(0, 31);
                if ($urandom_range(0, 1) != 0) and_m[w][b] = 1'b1;
                else                           or_m[w][b]  = 1'b1;
            end
            repeat ($urandom_range(0, 5)) @(posedge clk);
            pulse_start();
            if (r == 0) begin
                chk("restart_err_cnt", 32'(err_cnt), 32'd0);
                chk("restart_first_adr", 32'(fadr), 32'd0);
                chk("restart_first_dat", fdat, 32'd0);
                chk("restart_done", 32'(done), 32'd0);
                chk("restart_busy", 32'(busy), 32'd1);
            end
            wait_done(1'b0, n);
            chk("rand_cycles", 32'(n), 32'(RUN_CYC));
            chk_results("rand");
        end

        // Asynchronous reset in the middle of the read phase
        clear_faults();
        pulse_start();
        repeat (3 * DEPTH + 150) @(posedge clk);
        #4 rst_n = 1'b0;
        #1 chk_all_zero("midrst");
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        pulse_start();
        wait_done(1'b0, n);
        chk("rerun_cycles", 32'(n), 32'(RUN_CYC));
        chk_results("rerun");

`ifdef WB_BIST_TIMEOUT_EN
        sup_rd7 = 1'b1;
        pulse_start();
        wait_done(1'b0, n);
        sup_rd7 = 1'b0;
        chk("tmo_cycles", 32'(n), 32'(3 * DEPTH + 3 * 7 + TMO));
        chk("tmo_flag", 32'(timeout), 32'd1);
        chk("tmo_pass", 32'(pass), 32'd0);
        chk("tmo_cyc", 32'(cyc), 32'd0);
        chk("tmo_busy", 32'(busy), 32'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
